// File: rtl/sort_pkg.sv
// Shared types and default widths for the in-place bubble-sort sequencer.
package sort_pkg;
  localparam int N_DEF  = 8;
  localparam int CW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CMP  = 3'd2,
    WR1  = 3'd3,
    WR2  = 3'd4,
    DONE = 3'd5
  } state_t;
endpackage

// File: rtl/sort_ctrl.sv
// In-place ascending bubble sort over a wrap-around region of a 2R/1W memory.
// Compare costs 2 cycles, swap 4; start is only sampled in IDLE.
module sort_ctrl
  import sort_pkg::*;
#(
  parameter int n  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [n-1:0]  base_addr,
  input  logic [n-1:0]  len,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] swap_cnt,
  output logic [n-1:0]  rd_addr1,
  output logic [n-1:0]  rd_addr2,
  input  logic [n-1:0]  rd_data1,
  input  logic [n-1:0]  rd_data2,
  output logic [n-1:0]  wr_addr,
  output logic [n-1:0]  wr_data,
  output logic          wr_en
);

  state_t       state;
  logic [n-1:0] base_r;
  logic [n-1:0] idx;
  logic [n-1:0] last;
  logic         swapped;
  logic [n-1:0] d1_r;

  logic         more_pairs;
  logic         adv_swapped;
  logic         adv_done;
  logic [n-1:0] adv_idx;
  logic [n-1:0] adv_last;
  logic [n-1:0] adv_addr;

  // Pair-advance decision; from WR2 the pass flag is treated as already set.
  always_comb begin
    more_pairs  = (idx < last);
    adv_swapped = (state == WR2) ? 1'b1 : swapped;
    adv_done    = !more_pairs && (!adv_swapped || (last == '0));
    adv_idx     = more_pairs ? idx + 1'b1 : '0;
    adv_last    = more_pairs ? last : last - 1'b1;
    adv_addr    = base_r + adv_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      swap_cnt <= '0;
      rd_addr1 <= '0;
      rd_addr2 <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      idx      <= '0;
      last     <= '0;
      swapped  <= 1'b0;
      base_r   <= '0;
      d1_r     <= '0;
    end else begin
      done  <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            swap_cnt <= '0;
            if (len < n'(2)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              base_r   <= base_addr;
              last     <= len - n'(2);
              idx      <= '0;
              swapped  <= 1'b0;
              rd_addr1 <= base_addr;
              rd_addr2 <= base_addr + 1'b1;
              state    <= RD;
            end
          end
        end
        RD: state <= CMP;
        CMP: begin
          if (rd_data1 > rd_data2) begin
            d1_r    <= rd_data1;
            wr_en   <= 1'b1;
            wr_addr <= rd_addr1;
            wr_data <= rd_data2;
            state   <= WR1;
          end else if (adv_done) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx      <= adv_idx;
            last     <= adv_last;
            if (!more_pairs) swapped <= 1'b0;
            rd_addr1 <= adv_addr;
            rd_addr2 <= adv_addr + 1'b1;
            state    <= RD;
          end
        end
        WR1: begin
          wr_en   <= 1'b1;
          wr_addr <= rd_addr2;
          wr_data <= d1_r;
          state   <= WR2;
        end
        WR2: begin
          swapped <= 1'b1;
          if (swap_cnt != '1) swap_cnt <= swap_cnt + 1'b1;
          if (adv_done) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx      <= adv_idx;
            last     <= adv_last;
            if (!more_pairs) swapped <= 1'b0;
            rd_addr1 <= adv_addr;
            rd_addr2 <= adv_addr + 1'b1;
            state    <= RD;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_ctrl.sv
// Directed bench for sort_ctrl with a registered-read behavioural memory.
module tb_sort_ctrl;
  import sort_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  len;
  logic        busy;
  logic        done;
  logic [15:0] swap_cnt;
  logic [7:0]  rd_addr1;
  logic [7:0]  rd_addr2;
  logic [7:0]  rd_data1;
  logic [7:0]  rd_data2;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;

  logic [7:0]  mem [256];

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  int done_cyc;
  int wr_cnt;
  bit seen_wrap;
  logic busy_after;
  logic done_after;

  sort_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .swap_cnt(swap_cnt),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_data1 <= mem[rd_addr1];
    rd_data2 <= mem[rd_addr2];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load4(input logic [7:0] a, input logic [31:0] v);
    mem[a]         = v[31:24];
    mem[a + 8'd1]  = v[23:16];
    mem[a + 8'd2]  = v[15:8];
    mem[a + 8'd3]  = v[7:0];
  endtask

  function automatic logic [31:0] read4(input logic [7:0] a);
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  // Start in cycle 0, count cycles until done; optionally hold a bogus start while busy.
  task automatic run_sort(input logic [7:0] b, input logic [7:0] l, input bit noise);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    cyc       = 1;
    wr_cnt    = 0;
    seen_wrap = 1'b0;
    done_cyc  = -1;
    if (noise) begin
      start     = 1'b1;
      base_addr = 8'h00;
      len       = 8'h02;
    end
    while (done_cyc < 0 && cyc < 2000) begin
      if (wr_en) wr_cnt++;
      if (rd_addr1 == 8'hFF && rd_addr2 == 8'h00) seen_wrap = 1'b1;
      if (done) begin
        done_cyc = cyc;
        start    = 1'b0;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(done_cyc >= 0), 32'd1);
    @(posedge clk); #1;
    busy_after = busy;
    done_after = done;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    rst = 1'b1; start = 1'b0; base_addr = 8'h00; len = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_swap_cnt", 32'(swap_cnt), 32'd0);
    check("rst_rd_addr", {16'd0, rd_addr1, rd_addr2}, 32'd0);
    check("rst_wr_addr", {16'd0, wr_addr, wr_data}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Already sorted: one pass, no writes
    load4(8'h10, 32'h01020304);
    run_sort(8'h10, 8'd4, 1'b0);
    check("sorted_done_cyc", 32'(done_cyc), 32'd7);
    check("sorted_wr_cnt", 32'(wr_cnt), 32'd0);
    check("sorted_swap_cnt", 32'(swap_cnt), 32'd0);
    check("sorted_mem", read4(8'h10), 32'h01020304);

    // Reverse order: 6 swaps, 3 passes
    load4(8'h10, 32'h04030201);
    run_sort(8'h10, 8'd4, 1'b0);
    check("rev_mem", read4(8'h10), 32'h01020304);
    check("rev_swap_cnt", 32'(swap_cnt), 32'd6);
    check("rev_wr_cnt", 32'(wr_cnt), 32'd12);
    check("rev_done_cyc", 32'(done_cyc), 32'd25);
    check("rev_busy_after", 32'(busy_after), 32'd0);
    check("rev_done_after", 32'(done_after), 32'd0);

    // Region wrapping through 0xFF -> 0x00
    load4(8'hFE, 32'h09070503);
    run_sort(8'hFE, 8'd4, 1'b0);
    check("wrap_mem", read4(8'hFE), 32'h03050709);
    check("wrap_rd_addr2", 32'(seen_wrap), 32'd1);
    check("wrap_swap_cnt", 32'(swap_cnt), 32'd6);

    // Duplicates: equal values never swap
    mem[8'h20] = 8'd5; mem[8'h21] = 8'd5; mem[8'h22] = 8'd2;
    run_sort(8'h20, 8'd3, 1'b0);
    check("dup_mem", {8'h00, mem[8'h20], mem[8'h21], mem[8'h22]}, 32'h00020505);
    check("dup_swap_cnt", 32'(swap_cnt), 32'd2);
    check("dup_done_cyc", 32'(done_cyc), 32'd11);

    // Degenerate lengths: immediate done, no reads, counter cleared
    run_sort(8'h50, 8'd0, 1'b0);
    check("len0_done_cyc", 32'(done_cyc), 32'd1);
    check("len0_swap_cnt", 32'(swap_cnt), 32'd0);
    check("len0_rd_addr", {16'd0, rd_addr1, rd_addr2}, 32'h00002021);
    run_sort(8'h50, 8'd1, 1'b0);
    check("len1_done_cyc", 32'(done_cyc), 32'd1);
    check("len1_wr_cnt", 32'(wr_cnt), 32'd0);
    check("len1_rd_addr", {16'd0, rd_addr1, rd_addr2}, 32'h00002021);

    // start held high while busy with different base/len is ignored
    mem[8'h00] = 8'd9; mem[8'h01] = 8'd8;
    load4(8'h30, 32'h04030201);
    run_sort(8'h30, 8'd4, 1'b1);
    check("noise_mem", read4(8'h30), 32'h01020304);
    check("noise_other", {16'd0, mem[8'h00], mem[8'h01]}, 32'h00000908);
    check("noise_swap_cnt", 32'(swap_cnt), 32'd6);
    check("noise_done_cyc", 32'(done_cyc), 32'd25);
    check("noise_busy_after", 32'(busy_after), 32'd0);

    // Reset during CMP, then a clean re-sort
    load4(8'h40, 32'h04030201);
    base_addr = 8'h40; len = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_in_cmp", 32'(dut.state), 32'(CMP));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_state", 32'(dut.state), 32'(IDLE));
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_wr_en", 32'(wr_en), 32'd0);
    check("mid_mem", read4(8'h40), 32'h04030201);
    run_sort(8'h40, 8'd4, 1'b0);
    check("mid_resort_mem", read4(8'h40), 32'h01020304);
    check("mid_resort_swap_cnt", 32'(swap_cnt), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sort_ctrl.md
Name: sort_ctrl

Overview:
- Sequencer that bubble-sorts a contiguous region of the 256-entry, 2-read/1-write data memory in place, ascending, unsigned.
- Owns the memory's read and write ports while busy.
- Sits between the processor/testbench issuing start and the memory. Reads pairs over both read ports, which have 1-cycle registered read latency, and performs swaps as two single-port writes.

Parameters:
- n, 8, data and address width; memory depth 2^n.
- CW, 16, width of swap counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sort; sampled only in IDLE
- base_addr  in  n  address of first element
- len  in  n  element count (0..2^n-1)
- busy  out  1  high from cycle after start accepted through DONE
- done  out  1  one-cycle pulse at completion
- swap_cnt  out  CW  swaps performed in current/last sort; saturates at all-ones
- rd_addr1  out  n  to memory read port 1 (element a)
- rd_addr2  out  n  to memory read port 2 (element a+1)
- rd_data1  in  n  from memory, valid the cycle after address presented
- rd_data2  in  n  as above
- wr_addr  out  n  memory write address
- wr_data  out  n  memory write data
- wr_en  out  1  memory write enable

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, wr_en=0, swap_cnt=0, rd_addr1/2=0, wr_addr=0, wr_data=0, idx=0, last=0, swapped=0.
- States: IDLE, RD, CMP, WR1, WR2, DONE.
- Registers: idx (pair offset in current pass), last (final pair offset of pass), swapped (pass flag).
- Address arithmetic is modulo 2^n, so regions crossing 0xFF wrap to 0x00. Pair addresses are a=base+idx and a+1.
- IDLE + start:
  - If len<2, go to DONE. No memory access occurs and swap_cnt is cleared.
  - Otherwise latch base and len, set last=len-2, idx=0, swapped=0, swap_cnt=0, and go to RD.
  - start is ignored in all other states.
- RD: drive rd_addr1=a, rd_addr2=a+1; go to CMP.
- CMP: rd_data1/rd_data2 are valid.
  - If rd_data1 > rd_data2 (strict; equal values never swap): latch both values, go to WR1.
  - Otherwise take the pair-advance step.
- WR1: wr_en=1, wr_addr=a, wr_data=old rd_data2.
- WR2: wr_en=1, wr_addr=a+1, wr_data=old rd_data1. Also set swapped=1, increment swap_cnt (saturating), then take the pair-advance step.
- Pair-advance step:
  - If idx<last: idx++, go to RD.
  - Else if swapped==0 or last==0: go to DONE.
  - Else: last--, idx=0, swapped=0, go to RD.
- DONE: done=1 for exactly one cycle, busy=1 in this cycle; next state IDLE.
- busy=1 in RD/CMP/WR1/WR2/DONE.
- wr_en is 1 only in WR1/WR2.
- rd_addr1/2 hold their last value outside RD.
- Read-after-write hazard:
  - WR2's write commits at the end of WR2.
  - The next RD samples at the end of RD, one edge later, so it always sees updated data. No forwarding is required.
- Timing:
  - A non-swapping compare costs 2 cycles; a swapping compare costs 4.
  - Start accepted at edge 0 puts the block in RD in cycle 1.
- rst mid-sort: return to IDLE at the next edge, and no further writes occur.
  - A reset between WR1 and WR2 leaves one element duplicated in memory. This is an accepted, documented outcome.
- swap_cnt holds its value in IDLE until the next accepted start.

Decomposition:
- Shared package sort_pkg: state encoding constants (IDLE..DONE) and default widths (n=8, CW=16).
- Single module; no sub-module. A saturating counter is too small to split out.

Test Plan:
- Sorted [1,2,3,4] at base 0x10, len 4: no wr_en ever; one pass; done pulses in cycle 7 (start in cycle 0); swap_cnt=0.
- Reverse [4,3,2,1] at base 0x10: memory ends [1,2,3,4]; swap_cnt=6; exactly 12 wr_en cycles; busy falls the cycle after done.
- Wrap region: base 0xFE, len 4, mem[FE,FF,00,01]=[9,7,5,3] -> [3,5,7,9]; rd_addr2 goes 0xFF->0x00 correctly.
- Duplicates and edge lengths:
  - [5,5,2] sorts to [2,5,5] with swap_cnt=2.
  - len=0 and len=1 give done in cycle 1 with no memory access.
- start pulses while busy are ignored: latched base/len are unchanged and the result matches a single sort.
- rst asserted in a CMP cycle mid-sort: next cycle state IDLE, busy=0, wr_en=0. A new start then sorts the region to a correct final order.
